// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : 2-read/1-write register bank with bypass and per-register
//            pending bits for RAW-hazard stalls.
// Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic [DATA_W-1:0] data,
    input  logic              write,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall
);

    localparam int   NREG        = 2 ** ADDR_W;
    localparam logic ZERO_EN     = (ZERO_REG != 0);
    localparam logic BYPASS_EN   = (BYPASS != 0);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;
    logic              write_en;
    logic              hit_a;
    logic              hit_b;

    assign write_en = write & ~(ZERO_EN & (addr_d == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[addr_d] <= data;
        end
    end

    // A new producer (set) supersedes the retiring one (clear) on the same register.
    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < NREG; i++) begin
            if (pend_set && (pend_addr == ADDR_W'(i))) begin
                pend_nxt[i] = 1'b1;
            end else if (write && (addr_d == ADDR_W'(i))) begin
                pend_nxt[i] = 1'b0;
            end
        end
        if (ZERO_EN) begin
            pend_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign hit_a = BYPASS_EN & write & (addr_d == addr_a);
    assign hit_b = BYPASS_EN & write & (addr_d == addr_b);

    // The zero register wins over the bypass path.
    always_comb begin
        a = hit_a ? data : regs[addr_a];
        b = hit_b ? data : regs[addr_b];
        if (ZERO_EN && (addr_a == '0)) begin
            a = '0;
        end
        if (ZERO_EN && (addr_b == '0)) begin
            b = '0;
        end
    end

    assign busy_a = pend[addr_a] & ~hit_a;
    assign busy_b = pend[addr_b] & ~hit_b;
    assign stall  = busy_a | busy_b;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Directed self-checking bench for regfile_scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic clk;
    logic rst_n;

    // default instance: 32x32, ZERO_REG=1, BYPASS=1
    logic [4:0]  addr_a, addr_b, addr_d, pend_addr;
    logic [31:0] data, a, b;
    logic        write, pend_set, busy_a, busy_b, stall;

    // no-bypass instance: ZERO_REG=0, BYPASS=0
    logic [4:0]  n_addr_a, n_addr_b, n_addr_d, n_pend_addr;
    logic [31:0] n_data, n_a, n_b;
    logic        n_write, n_pend_set, n_busy_a, n_busy_b, n_stall;

    // wide instance: DATA_W=64, ADDR_W=3
    logic [2:0]  w_addr_a, w_addr_b, w_addr_d, w_pend_addr;
    logic [63:0] w_data, w_a, w_b;
    logic        w_write, w_pend_set, w_busy_a, w_busy_b, w_stall;

    int passed;
    int total;

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .addr_a(addr_a), .addr_b(addr_b),
        .addr_d(addr_d), .data(data), .write(write), .pend_set(pend_set),
        .pend_addr(pend_addr), .a(a), .b(b), .busy_a(busy_a),
        .busy_b(busy_b), .stall(stall)
    );

    regfile_scoreboard #(.ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .addr_a(n_addr_a), .addr_b(n_addr_b),
        .addr_d(n_addr_d), .data(n_data), .write(n_write), .pend_set(n_pend_set),
        .pend_addr(n_pend_addr), .a(n_a), .b(n_b), .busy_a(n_busy_a),
        .busy_b(n_busy_b), .stall(n_stall)
    );

    regfile_scoreboard #(.DATA_W(64), .ADDR_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .addr_a(w_addr_a), .addr_b(w_addr_b),
        .addr_d(w_addr_d), .data(w_data), .write(w_write), .pend_set(w_pend_set),
        .pend_addr(w_pend_addr), .a(w_a), .b(w_b), .busy_a(w_busy_a),
        .busy_b(w_busy_b), .stall(w_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        {addr_a, addr_b, addr_d, pend_addr, data, write, pend_set} = '0;
        {n_addr_a, n_addr_b, n_addr_d, n_pend_addr, n_data, n_write, n_pend_set} = '0;
        {w_addr_a, w_addr_b, w_addr_d, w_pend_addr, w_data, w_write, w_pend_set} = '0;

        // Reset state
        #2;
        check("rst_a", 64'(a), 64'h0);
        check("rst_b", 64'(b), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill every register with all-ones
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            write  = 1'b1;
            addr_d = 5'(i);
            data   = 32'hFFFF_FFFF;
        end
        @(negedge clk);
        write     = 1'b0;
        addr_a    = 5'd5;
        addr_b    = 5'd31;
        pend_set  = 1'b1;
        pend_addr = 5'd5;
        #1;
        check("fill_a", 64'(a), 64'hFFFF_FFFF);
        check("fill_b", 64'(b), 64'hFFFF_FFFF);
        check("zero_after_fill", 64'(dut.regs[0]), 64'h0);
        @(posedge clk);
        #1;
        pend_set = 1'b0;
        check("pend5_busy", 64'(busy_a), 64'h1);
        check("pend5_stall", 64'(stall), 64'h1);

        // Mid-cycle asynchronous reset
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", 64'(a), 64'h0);
        check("async_rst_b", 64'(b), 64'h0);
        check("async_rst_stall", 64'(stall), 64'h0);
        // writes during reset must be ignored
        write  = 1'b1;
        addr_d = 5'd6;
        data   = 32'h0000_007B;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n  = 1'b1;
        write  = 1'b0;
        addr_a = 5'd6;
        #1;
        check("rst_ignores_write", 64'(a), 64'h0);

        // Zero register
        @(negedge clk);
        write     = 1'b1;
        addr_d    = 5'd0;
        data      = 32'h1;
        pend_set  = 1'b1;
        pend_addr = 5'd0;
        addr_a    = 5'd0;
        #1;
        check("zero_bypass_a", 64'(a), 64'h0);
        check("zero_busy_pre", 64'(busy_a), 64'h0);
        @(posedge clk);
        #1;
        write    = 1'b0;
        pend_set = 1'b0;
        #1;
        check("zero_a", 64'(a), 64'h0);
        check("zero_busy", 64'(busy_a), 64'h0);

        // Bypass on port A; port B unaffected
        @(negedge clk);
        write  = 1'b1;
        addr_d = 5'd1;
        data   = 32'h2;
        addr_a = 5'd1;
        addr_b = 5'd2;
        #1;
        check("bypass_pre_a", 64'(a), 64'h2);
        check("bypass_pre_b", 64'(b), 64'h0);
        @(posedge clk);
        #1;
        write = 1'b0;
        #1;
        check("bypass_post_a", 64'(a), 64'h2);

        // Scoreboard set then retire
        @(negedge clk);
        pend_set  = 1'b1;
        pend_addr = 5'd3;
        @(posedge clk);
        #1;
        pend_set = 1'b0;
        addr_a   = 5'd3;
        addr_b   = 5'd3;
        #1;
        check("sb_busy_a", 64'(busy_a), 64'h1);
        check("sb_busy_b", 64'(busy_b), 64'h1);
        check("sb_stall", 64'(stall), 64'h1);
        @(negedge clk);
        write  = 1'b1;
        addr_d = 5'd3;
        data   = 32'h5;
        addr_b = 5'd2;
        #1;
        check("sb_retire_busy", 64'(busy_a), 64'h0);
        check("sb_retire_a", 64'(a), 64'h5);
        check("sb_retire_stall", 64'(stall), 64'h0);
        @(posedge clk);
        #1;
        write = 1'b0;
        #1;
        check("sb_after_busy", 64'(busy_a), 64'h0);
        check("sb_after_a", 64'(a), 64'h5);

        // Collision: set and write on the same register
        @(negedge clk);
        write     = 1'b1;
        addr_d    = 5'd4;
        data      = 32'h9;
        pend_set  = 1'b1;
        pend_addr = 5'd4;
        addr_a    = 5'd4;
        @(posedge clk);
        #1;
        write    = 1'b0;
        pend_set = 1'b0;
        #1;
        check("coll_busy", 64'(busy_a), 64'h1);
        check("coll_stall", 64'(stall), 64'h1);
        check("coll_a", 64'(a), 64'h9);

        // No-bypass instance: old value until the edge; reg0 ordinary
        @(negedge clk);
        n_write    = 1'b1;
        n_addr_d   = 5'd1;
        n_data     = 32'h2;
        n_addr_a   = 5'd1;
        n_pend_set = 1'b1;
        n_pend_addr = 5'd3;
        #1;
        check("nb_pre_a", 64'(n_a), 64'h0);
        @(posedge clk);
        #1;
        n_write    = 1'b0;
        n_pend_set = 1'b0;
        #1;
        check("nb_post_a", 64'(n_a), 64'h2);
        @(negedge clk);
        n_write  = 1'b1;
        n_addr_d = 5'd3;
        n_data   = 32'h5;
        n_addr_a = 5'd3;
        #1;
        check("nb_busy_pre", 64'(n_busy_a), 64'h1);
        check("nb_stall_pre", 64'(n_stall), 64'h1);
        check("nb_a_pre", 64'(n_a), 64'h0);
        @(posedge clk);
        #1;
        n_addr_d = 5'd0;
        n_data   = 32'h7;
        n_addr_b = 5'd0;
        #1;
        check("nb_busy_post", 64'(n_busy_a), 64'h0);
        check("nb_a_post", 64'(n_a), 64'h5);
        @(posedge clk);
        #1;
        n_write = 1'b0;
        #1;
        check("nb_reg0_b", 64'(n_b), 64'h7);

        // Wide instance
        @(negedge clk);
        w_write  = 1'b1;
        w_addr_d = 3'd7;
        w_data   = 64'hDEAD_BEEF_0123_4567;
        @(posedge clk);
        #1;
        w_write  = 1'b0;
        w_addr_b = 3'd7;
        #1;
        check("wide_b", w_b, 64'hDEAD_BEEF_0123_4567);
        check("wide_a0", w_a, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
